// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch program counter: FSM state
// encoding, default vectors and the alignment check used on redirects.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] PC_DEF_TRAP_VEC  = 32'h0000_0100;

  // Only the two low target bits can violate 2- or 4-byte alignment.
  function automatic logic is_misaligned(input logic [1:0]  target_lsb,
                                         input int unsigned ialign);
    if (ialign == 2) begin
      return target_lsb[0];
    end
    return |target_lsb;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC / next-state priority mux for pc_unit.
// Holds no state; the top level registers everything it produces.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(PC_DEF_TRAP_VEC),
  parameter int unsigned     IALIGN   = 4
) (
  input  pc_state_e       state_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            fetch_ready_i,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_req_i,
  input  logic            halt_req_i,
  input  logic            resume_req_i,
  output logic [XLEN-1:0] next_pc_o,
  output pc_state_e       next_state_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] pc_inc;
  logic            target_misaligned;

  assign pc_inc            = pc_i + XLEN'(IALIGN);
  assign target_misaligned = is_misaligned(redirect_target_i[1:0], IALIGN);

  // Redirect and trap deliberately bypass stall/fetch_ready: the in-flight
  // fetch is squashed rather than completed.
  always_comb begin
    next_pc_o    = pc_i;
    next_state_o = state_i;
    misalign_o   = 1'b0;
    case (state_i)
      ST_BOOT: begin
        next_state_o = ST_RUN;
      end
      ST_RUN: begin
        if (trap_req_i) begin
          next_pc_o = TRAP_VEC;
        end else if (redirect_valid_i) begin
          if (target_misaligned) begin
            next_pc_o  = TRAP_VEC;
            misalign_o = 1'b1;
          end else begin
            next_pc_o = redirect_target_i;
          end
        end else if (halt_req_i) begin
          next_state_o = ST_HALT;
        end else if (!stall_i && fetch_ready_i) begin
          next_pc_o = pc_inc;
        end
      end
      ST_HALT: begin
        if (trap_req_i) begin
          next_pc_o    = TRAP_VEC;
          next_state_o = ST_RUN;
        end else if (resume_req_i) begin
          next_state_o = ST_RUN;
        end
      end
      default: begin
        next_state_o = ST_BOOT;
      end
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: registers PC, FSM state and misalignment status,
// and presents the PC to instruction fetch through a valid/ready handshake.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(PC_DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(PC_DEF_TRAP_VEC),
  parameter int unsigned     IALIGN    = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            fetch_ready,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_req,
  input  logic            halt_req,
  input  logic            resume_req,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr,
  output logic            halted
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_err_q, misalign_err_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;
  logic            sel_misalign;

  pc_next_sel #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC),
    .IALIGN   (IALIGN)
  ) u_next_sel (
    .state_i           (state_q),
    .pc_i              (pc_q),
    .fetch_ready_i     (fetch_ready),
    .stall_i           (stall),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .trap_req_i        (trap_req),
    .halt_req_i        (halt_req),
    .resume_req_i      (resume_req),
    .next_pc_o         (pc_d),
    .next_state_o      (state_d),
    .misalign_o        (sel_misalign)
  );

  // The error flag is a one-cycle pulse; the address is sticky until the
  // next offending redirect.
  always_comb begin
    misalign_err_d  = sel_misalign;
    misalign_addr_d = misalign_addr_q;
    if (sel_misalign) begin
      misalign_addr_d = redirect_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= ST_BOOT;
      pc_q            <= RESET_VEC;
      misalign_err_q  <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      misalign_err_q  <= misalign_err_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  always_comb begin
    pc_valid = (state_q == ST_RUN);
    halted   = (state_q == ST_HALT);
  end

  assign pc_out        = pc_q;
  assign misalign_err  = misalign_err_q;
  assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: two instances (IALIGN=4 and IALIGN=2)
// share stimulus and are compared every cycle against a behavioural model.
module tb_pc_unit;

  localparam logic [31:0] RST_V  = 32'h0000_0000;
  localparam logic [31:0] TRAP_V = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset_n, fetch_ready, stall, redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_req, halt_req, resume_req;

  logic [31:0] a_pc, a_addr, b_pc, b_addr;
  logic        a_valid, a_err, a_halted, b_valid, b_err, b_halted;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  // Behavioural model state, index 0 = IALIGN 4, index 1 = IALIGN 2
  logic [31:0] m_pc[2];
  logic [31:0] m_addr[2];
  bit          m_boot[2];
  bit          m_halt[2];
  bit          m_err[2];

  always #5 clk = ~clk;

  pc_unit #(.XLEN(32), .RESET_VEC(RST_V), .TRAP_VEC(TRAP_V), .IALIGN(4)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .fetch_ready(fetch_ready), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_req(trap_req), .halt_req(halt_req), .resume_req(resume_req),
    .pc_out(a_pc), .pc_valid(a_valid), .misalign_err(a_err),
    .misalign_addr(a_addr), .halted(a_halted)
  );

  pc_unit #(.XLEN(32), .RESET_VEC(RST_V), .TRAP_VEC(TRAP_V), .IALIGN(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .fetch_ready(fetch_ready), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_req(trap_req), .halt_req(halt_req), .resume_req(resume_req),
    .pc_out(b_pc), .pc_valid(b_valid), .misalign_err(b_err),
    .misalign_addr(b_addr), .halted(b_halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge of architectural behaviour, in plain terms.
  task automatic model_step(input int k, input int unsigned al);
    bit odd_target;
    odd_target = (redirect_target % al) != 0;
    if (!reset_n) begin
      m_pc[k] = RST_V; m_boot[k] = 1; m_halt[k] = 0; m_err[k] = 0; m_addr[k] = '0;
    end else if (m_boot[k]) begin
      m_boot[k] = 0; m_err[k] = 0;
    end else if (m_halt[k]) begin
      m_err[k] = 0;
      if (trap_req) begin
        m_pc[k] = TRAP_V; m_halt[k] = 0;
      end else if (resume_req) begin
        m_halt[k] = 0;
      end
    end else begin
      m_err[k] = 0;
      if (trap_req) m_pc[k] = TRAP_V;
      else if (redirect_valid && odd_target) begin
        m_pc[k] = TRAP_V; m_err[k] = 1; m_addr[k] = redirect_target;
      end else if (redirect_valid) m_pc[k] = redirect_target;
      else if (halt_req) m_halt[k] = 1;
      else if (fetch_ready && !stall) m_pc[k] = m_pc[k] + al;
    end
  endtask

  task automatic compare_all();
    check_eq("a_pc",     a_pc,           m_pc[0]);
    check_eq("a_valid",  {31'd0, a_valid},  {31'd0, !m_boot[0] && !m_halt[0]});
    check_eq("a_err",    {31'd0, a_err},    {31'd0, m_err[0]});
    check_eq("a_addr",   a_addr,         m_addr[0]);
    check_eq("a_halted", {31'd0, a_halted}, {31'd0, m_halt[0]});
    check_eq("b_pc",     b_pc,           m_pc[1]);
    check_eq("b_valid",  {31'd0, b_valid},  {31'd0, !m_boot[1] && !m_halt[1]});
    check_eq("b_err",    {31'd0, b_err},    {31'd0, m_err[1]});
    check_eq("b_addr",   b_addr,         m_addr[1]);
    check_eq("b_halted", {31'd0, b_halted}, {31'd0, m_halt[1]});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0, 4);
    model_step(1, 2);
    #1;
    compare_all();
  endtask

  task automatic set_in(input logic rst, input logic rdy, input logic stl,
                        input logic rv, input logic [31:0] tgt,
                        input logic trp, input logic hlt, input logic res);
    reset_n = rst; fetch_ready = rdy; stall = stl; redirect_valid = rv;
    redirect_target = tgt; trap_req = trp; halt_req = hlt; resume_req = res;
  endtask

  initial begin
    logic [31:0] tgt;
    set_in(0, 1, 0, 0, '0, 0, 0, 0);

    // Reset and boot
    cycle(); cycle();
    check_eq("rst_pc", a_pc, RST_V);
    check_eq("rst_valid", {31'd0, a_valid}, 32'd0);
    set_in(1, 1, 0, 0, '0, 0, 0, 0);
    cycle();
    check_eq("boot_pc0", a_pc, 32'h0);
    check_eq("boot_valid", {31'd0, a_valid}, 32'd1);
    cycle(); check_eq("seq_4", a_pc, 32'h4);
    cycle(); check_eq("seq_8", a_pc, 32'h8);

    // Backpressure then stall
    fetch_ready = 0;
    repeat (3) cycle();
    check_eq("bp_hold", a_pc, 32'h8);
    fetch_ready = 1; stall = 1;
    repeat (2) cycle();
    check_eq("stall_hold", a_pc, 32'h8);
    stall = 0;
    cycle(); check_eq("seq_c", a_pc, 32'hC);

    // Redirect, trap priority, redirect under stall
    set_in(1, 1, 0, 1, 32'h200, 0, 0, 0); cycle();
    check_eq("redir", a_pc, 32'h200);
    set_in(1, 1, 0, 1, 32'h300, 1, 0, 0); cycle();
    check_eq("trap_over_redir", a_pc, TRAP_V);
    set_in(1, 0, 1, 1, 32'h400, 0, 0, 0); cycle();
    check_eq("redir_stall", a_pc, 32'h400);

    // Misaligned redirect on both alignments
    set_in(1, 1, 0, 1, 32'h202, 0, 0, 0); cycle();
    check_eq("mis_pc_a", a_pc, TRAP_V);
    check_eq("mis_err_a", {31'd0, a_err}, 32'd1);
    check_eq("mis_addr_a", a_addr, 32'h202);
    check_eq("ok_pc_b", b_pc, 32'h202);
    set_in(1, 1, 0, 0, '0, 0, 0, 0); cycle();
    check_eq("mis_pulse_a", {31'd0, a_err}, 32'd0);
    check_eq("mis_addr_held", a_addr, 32'h202);

    // Halt / resume / trap out of halt
    set_in(1, 1, 0, 1, 32'h40, 0, 0, 0); cycle();
    set_in(1, 1, 0, 0, '0, 0, 1, 0); cycle();
    halt_req = 0;
    repeat (5) cycle();
    check_eq("halt_pc", a_pc, 32'h40);
    check_eq("halt_flag", {31'd0, a_halted}, 32'd1);
    check_eq("halt_valid", {31'd0, a_valid}, 32'd0);
    set_in(1, 1, 0, 1, 32'h80, 0, 0, 1); cycle();
    check_eq("resume_pc", a_pc, 32'h40);
    resume_req = 0; redirect_valid = 0; cycle();
    check_eq("resume_seq", a_pc, 32'h44);
    halt_req = 1; cycle();
    set_in(1, 1, 0, 0, '0, 1, 0, 1); cycle();
    check_eq("halt_trap_pc", a_pc, TRAP_V);
    check_eq("halt_trap_run", {31'd0, a_halted}, 32'd0);

    // Wrap and mid-operation reset
    set_in(1, 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0); cycle();
    redirect_valid = 0; cycle();
    check_eq("wrap_pc", a_pc, 32'h0);
    check_eq("wrap_err", {31'd0, a_err}, 32'd0);
    halt_req = 1; cycle();
    reset_n = 0; cycle();
    check_eq("rst_in_halt_pc", a_pc, RST_V);
    check_eq("rst_in_halt_flag", {31'd0, a_halted}, 32'd0);
    set_in(1, 1, 0, 0, '0, 0, 0, 0); cycle(); cycle();
    set_in(0, 1, 0, 1, 32'h500, 0, 0, 0); cycle();
    check_eq("rst_on_redir", a_pc, RST_V);
    check_eq("rst_on_redir_v", {31'd0, a_valid}, 32'd0);

    // Randomised phase
    for (int unsigned i = 0; i < 3000; i++) begin
      case ($urandom_range(3))
        0: tgt = $urandom & 32'hFFFF_FFFC;
        1: tgt = ($urandom & 32'hFFFF_FFFC) | 32'h2;
        2: tgt = $urandom;
        default: tgt = 32'hFFFF_FFF0 | ($urandom & 32'hC);
      endcase
      set_in($urandom_range(99) >= 2,
             $urandom_range(3) != 0,
             $urandom_range(4) == 0,
             $urandom_range(5) == 0,
             tgt,
             $urandom_range(15) == 0,
             $urandom_range(11) == 0,
             $urandom_range(3) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
